wb_ls_seq: RTL
==============

WB_LS_SEQ -- requirements
Module: wb_ls_seq

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles one bus beat waits for ACK_I before abort (legal range 1..15).
REQ-002 CLK_I  input  1  the single clock; all state changes on its rising edge.
REQ-003 RST_I  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  1  CPU load/store request, sampled only in IDLE.
REQ-005 req_we_i  input  1  1 = store, 0 = load.
REQ-006 req_wide_i  input  1  1 = 32-bit access (two 16-bit beats), 0 = 16-bit access (one beat).
REQ-007 req_adr_i  input  16  base halfword address.
REQ-008 req_dat_i  input  32  store data.
REQ-009 busy_o  output  1  CPU stall; high in every state except IDLE.
REQ-010 done_o  output  1  one-cycle pulse on successful completion.
REQ-011 err_o  output  1  one-cycle pulse on timeout abort.
REQ-012 rd_dat_o  output  32  load result, held until the next load updates it.
REQ-013 CYC_O, STB_O  output  1 each  bus cycle/strobe.
REQ-014 WE_O  output  1  bus write enable.
REQ-015 ADR_O  output  16  bus address.
REQ-016 DAT_O  output  16  bus write data.
REQ-017 DAT_I  input  16  bus read data.
REQ-018 ACK_I  input  1  bus acknowledge.

Function
REQ-019 FSM states: IDLE, BEAT_LO, BEAT_HI, RESP, ERR.
REQ-020 IDLE: when req_i=1, latch we/wide/adr/dat into internal registers and go to BEAT_LO; req_i in any other state ignored.
REQ-021 CYC_O=STB_O=1 exactly in BEAT_LO and BEAT_HI; WE_O = latched we in those states, else 0.
REQ-022 BEAT_LO: ADR_O = latched adr, DAT_O = dat[15:0]; BEAT_HI: ADR_O = adr+1 modulo 2^16 (0xFFFF wraps to 0x0000), DAT_O = dat[31:16]; outside beats ADR_O and DAT_O = 0.
REQ-023 BEAT_LO with ACK_I=1: wide -> BEAT_HI, narrow -> RESP; BEAT_HI with ACK_I=1 -> RESP.
REQ-024 Loads: on BEAT_LO ACK, rd_dat_o[15:0] <= DAT_I and, if narrow, rd_dat_o[31:16] <= 0 (zero-extend); on BEAT_HI ACK, rd_dat_o[31:16] <= DAT_I; stores never modify rd_dat_o.
REQ-025 RESP: done_o=1 for that one cycle, busy_o=1, next state IDLE.
REQ-026 Wait counter (4 bit) cleared on entry to each beat state, incremented each beat cycle without ACK_I; beat cycle where counter = TIMEOUT-1 and ACK_I=0 -> ERR.
REQ-027 ACK_I in the same cycle as timeout expiry wins: normal transition, no ERR.
REQ-028 ERR: err_o=1 one cycle, done_o=0, bus strobes 0, rd_dat_o keeps any half captured before the abort, next state IDLE.
REQ-029 ACK_I sampled outside BEAT_LO/BEAT_HI is ignored and changes no state.
REQ-030 Latency with zero-wait ACK: accept edge -> done_o at 2nd cycle after accept (narrow), 3rd (wide); each wait cycle adds one.
REQ-031 Back-to-back: new request accepted at earliest in the IDLE cycle following RESP/ERR.

Reset
REQ-032 RST_I=1 at a rising edge forces IDLE, clears wait counter, latched registers and rd_dat_o to 0.
REQ-033 During and after reset cycle: busy_o, done_o, err_o, CYC_O, STB_O, WE_O = 0, ADR_O = DAT_O = 0.
REQ-034 Reset mid-beat drops CYC_O/STB_O at that edge; no done_o or err_o is generated for the aborted access.

Verification
REQ-035 Wide store adr=0x0010, dat=0xDEADBEEF, ACK each beat immediately -> beat1 ADR_O=0x0010 DAT_O=0xBEEF WE_O=1, beat2 ADR_O=0x0011 DAT_O=0xDEAD, done_o 3 cycles after accept.
REQ-036 Wide load adr=0xFFFF, DAT_I=0x1234 then 0xABCD -> ADR_O 0xFFFF then 0x0000, rd_dat_o=0xABCD1234 at done_o.
REQ-037 Narrow load after REQ-036, DAT_I=0x5555 with 2 wait cycles -> rd_dat_o=0x00005555, done_o 4 cycles after accept.
REQ-038 TIMEOUT=15, no ACK in BEAT_LO -> STB_O high 15 cycles, err_o pulse, done_o never, busy_o low next cycle; repeat with ACK on 15th cycle -> no err_o.
REQ-039 RST_I asserted in BEAT_HI of a wide load -> all outputs 0 next cycle, rd_dat_o=0, fresh request then completes normally.
REQ-040 req_i held high and spurious ACK_I pulses during busy and idle -> exactly one access per IDLE acceptance, no state change from idle ACK_I.

Source files
------------

// File: rtl/wb_ls_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_ls_seq_if
// Brief    : 16-bit Wishbone-style bus used by the load/store sequencer.
// Revision : 1.0
// ============================================================================
interface wb_ls_seq_if;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [15:0] ADR_O;
    logic [15:0] DAT_O;
    logic [15:0] DAT_I;
    logic        ACK_I;

    modport master (
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        output DAT_I, ACK_I
    );
endinterface
`default_nettype wire

// File: rtl/wb_ls_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_ls_seq
// Brief    : CPU load/store sequencer issuing one or two 16-bit bus beats.
// Revision : 1.0
// ============================================================================
module wb_ls_seq #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        req_i,
    input  logic        req_we_i,
    input  logic        req_wide_i,
    input  logic [15:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rd_dat_o,
    wb_ls_seq_if.master bus
);

    localparam logic [3:0] C_TMO_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BEAT_LO = 3'd1,
        ST_BEAT_HI = 3'd2,
        ST_RESP    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t      state_q,    state_d;
    logic [3:0]  wait_q,     wait_d;
    logic        req_we_q,   req_we_d;
    logic        req_wide_q, req_wide_d;
    logic [15:0] req_adr_q,  req_adr_d;
    logic [31:0] req_dat_q,  req_dat_d;
    logic [31:0] rd_dat_q,   rd_dat_d;

    // Outputs are registered from the next state so they line up with it.
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;
    logic        bus_cyc_q,  bus_cyc_d;
    logic        bus_we_q,   bus_we_d;
    logic [15:0] bus_adr_q,  bus_adr_d;
    logic [15:0] bus_dat_q,  bus_dat_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        req_we_d   = req_we_q;
        req_wide_d = req_wide_q;
        req_adr_d  = req_adr_q;
        req_dat_d  = req_dat_q;
        rd_dat_d   = rd_dat_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    req_we_d   = req_we_i;
                    req_wide_d = req_wide_i;
                    req_adr_d  = req_adr_i;
                    req_dat_d  = req_dat_i;
                    wait_d     = 4'd0;
                    state_d    = ST_BEAT_LO;
                end
            end
            ST_BEAT_LO: begin
                if (bus.ACK_I) begin
                    if (!req_we_q) begin
                        rd_dat_d[15:0] = bus.DAT_I;
                        if (!req_wide_q) begin
                            rd_dat_d[31:16] = 16'h0000;
                        end
                    end
                    wait_d  = 4'd0;
                    state_d = req_wide_q ? ST_BEAT_HI : ST_RESP;
                end else if (wait_q == C_TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_BEAT_HI: begin
                if (bus.ACK_I) begin
                    if (!req_we_q) begin
                        rd_dat_d[31:16] = bus.DAT_I;
                    end
                    wait_d  = 4'd0;
                    state_d = ST_RESP;
                end else if (wait_q == C_TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_RESP);
        err_d     = (state_d == ST_ERR);
        bus_cyc_d = (state_d == ST_BEAT_LO) || (state_d == ST_BEAT_HI);
        bus_we_d  = bus_cyc_d && req_we_d;
        bus_adr_d = 16'h0000;
        bus_dat_d = 16'h0000;
        if (state_d == ST_BEAT_LO) begin
            bus_adr_d = req_adr_d;
            bus_dat_d = req_dat_d[15:0];
        end else if (state_d == ST_BEAT_HI) begin
            bus_adr_d = req_adr_d + 16'd1;
            bus_dat_d = req_dat_d[31:16];
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            wait_q     <= 4'd0;
            req_we_q   <= 1'b0;
            req_wide_q <= 1'b0;
            req_adr_q  <= 16'h0000;
            req_dat_q  <= 32'h0000_0000;
            rd_dat_q   <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bus_cyc_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_adr_q  <= 16'h0000;
            bus_dat_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            req_we_q   <= req_we_d;
            req_wide_q <= req_wide_d;
            req_adr_q  <= req_adr_d;
            req_dat_q  <= req_dat_d;
            rd_dat_q   <= rd_dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            bus_cyc_q  <= bus_cyc_d;
            bus_we_q   <= bus_we_d;
            bus_adr_q  <= bus_adr_d;
            bus_dat_q  <= bus_dat_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rd_dat_o  = rd_dat_q;
    assign bus.CYC_O = bus_cyc_q;
    assign bus.STB_O = bus_cyc_q;
    assign bus.WE_O  = bus_we_q;
    assign bus.ADR_O = bus_adr_q;
    assign bus.DAT_O = bus_dat_q;

endmodule
`default_nettype wire
